d_uncache_bridge: RTL and testbench

D_UNCACHE_BRIDGE -- requirements
Module: d_uncache_bridge

---
 rtl/dbridge_pkg.sv | 37 +++
 rtl/wbuf_fifo.sv | 54 +++++
 rtl/d_uncache_bridge.sv | 192 +++++++++++++++++++
 tb/tb_d_uncache_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbridge_pkg.sv
// Shared types and AXI constants for the uncached data bridge.
// Holds the FSM state encodings, the posted-store entry layout and the line-address helper.
package dbridge_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam int         RESP_ERR_BIT = 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_ADDR = 2'd2,
        R_DATA = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [1:0]  size;
    } wbuf_entry_t;

    localparam int WBUF_ENTRY_W = $bits(wbuf_entry_t);

    // Aligns a byte address down to the start of a line of line_words 32-bit words.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_words);
        return addr & ~(32'(line_words * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store buffer: a small circular FIFO with occupancy count.
// A push is accepted while full only when a pop happens in the same cycle.
module wbuf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 head_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/d_uncache_bridge.sv
// Uncached CPU data port to AXI bridge: posted stores through a write buffer,
// blocking word/line loads that never overtake buffered stores.
//
// state  | meaning
// W_IDLE | no store in flight
// W_ADDR | presenting buffer head on AW
// W_DATA | presenting buffer head on W
// W_RESP | waiting for B, pops head on response
// R_IDLE | no load in flight
// R_WAIT | load held until write buffer drained and write side idle
// R_ADDR | presenting AR
// R_DATA | accepting R beats until rlast
module d_uncache_bridge
    import dbridge_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int LINE_WORDS = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            cpu_en,
    input  logic [3:0]      cpu_wen,
    input  logic [31:0]     cpu_addr,
    input  logic [31:0]     cpu_wdata,
    input  logic [1:0]      cpu_size,
    input  logic            cpu_line,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_rvalid,
    output logic            stall,
    output logic            bus_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;
    wbuf_entry_t push_entry;
    wbuf_entry_t head;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(WBUF_DEPTH+1)-1:0] fifo_count;
    logic        is_store, is_load, ld_start, ld_done;
    logic        r_fire, b_fire;
    logic [31:0] araddr_q;
    logic [3:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic        unused_ok;

    assign is_store = cpu_en & (|cpu_wen);
    assign is_load  = cpu_en & ~(|cpu_wen);
    // ld_done marks the cycle the CPU still presents a load that has just completed.
    assign ld_start = (rd_state == R_IDLE) & is_load & ~ld_done;
    assign r_fire   = (rd_state == R_DATA) & rvalid;
    assign b_fire   = (wr_state == W_RESP) & bvalid;

    assign fifo_pop  = b_fire;
    assign fifo_push = is_store & (rd_state == R_IDLE) & (~fifo_full | fifo_pop);

    assign push_entry = '{addr: cpu_addr, wdata: cpu_wdata, wen: cpu_wen, size: cpu_size};

    wbuf_fifo #(
        .WIDTH (WBUF_ENTRY_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        stall = 1'b0;
        if (rd_state != R_IDLE)
            stall = 1'b1;
        else if (is_load & ~ld_done)
            stall = 1'b1;
        else if (is_store & fifo_full & ~fifo_pop)
            stall = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (!fifo_empty) wr_next = W_ADDR;
            W_ADDR:  if (awready)     wr_next = W_DATA;
            W_DATA:  if (wready)      wr_next = W_RESP;
            W_RESP:  if (bvalid)      wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ld_start) rd_next = R_WAIT;
            R_WAIT:  if (fifo_empty && wr_state == W_IDLE) rd_next = R_ADDR;
            R_ADDR:  if (arready) rd_next = R_DATA;
            R_DATA:  if (rvalid && rlast) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            ld_done    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            if (ld_start) begin
                araddr_q <= cpu_line ? line_align(cpu_addr, LINE_WORDS) : cpu_addr;
                arlen_q  <= cpu_line ? 4'(LINE_WORDS - 1) : 4'd0;
                arsize_q <= cpu_line ? SIZE_WORD : {1'b0, cpu_size};
            end
            ld_done    <= r_fire & rlast;
            cpu_rvalid <= r_fire;
            if (r_fire) cpu_rdata <= rdata;
            bus_err    <= (r_fire & rresp[RESP_ERR_BIT]) | (b_fire & bresp[RESP_ERR_BIT]);
        end
    end

    assign arid    = '0;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = BURST_INCR;
    assign arvalid = (rd_state == R_ADDR);
    assign rready  = (rd_state == R_DATA);

    assign awid    = '0;
    assign awaddr  = head.addr;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, head.size};
    assign awburst = BURST_INCR;
    assign awvalid = (wr_state == W_ADDR);
    assign wid     = '0;
    assign wdata   = head.wdata;
    assign wstrb   = head.wen;
    assign wvalid  = (wr_state == W_DATA);
    assign wlast   = wvalid;
    assign bready  = (wr_state == W_RESP);

    // Ids and the low response bits carry nothing this bridge acts on.
    assign unused_ok = ^{rid, bid, rresp[0], bresp[0], fifo_count};

endmodule

// File: tb/tb_d_uncache_bridge.sv
// Scoreboard bench for d_uncache_bridge: a simple AXI slave model, expected
// AR/AW/W/read-data queues filled at stimulus time and drained on handshakes.
`timescale 1ns/1ps
module tb_d_uncache_bridge;

    localparam int ID_W = 4, LINE_WORDS = 4, WBUF_DEPTH = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic cpu_en = 0, cpu_line = 0;
    logic [3:0] cpu_wen = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [1:0] cpu_size = 0;
    logic [31:0] cpu_rdata;
    logic cpu_rvalid, stall, bus_err;
    logic [ID_W-1:0] arid, awid, wid;
    logic [ID_W-1:0] rid = '0, bid = '0;
    logic [31:0] araddr, awaddr, wdata;
    logic [31:0] rdata = '0;
    logic [3:0] arlen, awlen, wstrb;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst;
    logic [1:0] rresp = '0, bresp = '0;
    logic arvalid, rready, awvalid, wvalid, wlast, bready;
    logic arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;

    always #5 aclk = ~aclk;

    d_uncache_bridge #(.ID_W(ID_W), .LINE_WORDS(LINE_WORDS), .WBUF_DEPTH(WBUF_DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_line(cpu_line), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .stall(stall), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ar_pack(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
        return {25'd0, a, l, s};
    endfunction

    // scoreboard queues and slave-model state
    logic [63:0] exp_ar_q[$];
    logic [63:0] exp_aw_q[$];
    logic [63:0] exp_w_q[$];
    logic [31:0] exp_rd_q[$];
    logic [33:0] rbeat_q[$];
    logic [1:0]  bresp_q[$];
    logic arready_en = 1, awready_en = 1, wready_en = 1, rvalid_en = 1, bvalid_en = 1;
    logic [1:0] bresp_val = 2'b00;
    bit ar_fire, aw_fire, w_fire, r_fire, b_fire, err_exp_next;
    int r_left = 0, ar_len_cap = 0;
    int ar_total = 0, aw_total = 0, r_total = 0, b_total = 0, store_total = 0, err_pulses = 0;

    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
                rdata = '0; rresp = '0; bresp = '0;
                r_left = 0; bresp_q.delete();
                ar_fire = 0; aw_fire = 0; w_fire = 0; r_fire = 0; b_fire = 0; err_exp_next = 0;
            end else begin
                if (r_fire) begin
                    void'(rbeat_q.pop_front());
                    r_left--;
                end
                if (ar_fire) r_left = ar_len_cap + 1;
                if (w_fire) bresp_q.push_back(bresp_val);
                if (b_fire) void'(bresp_q.pop_front());
                arready = arready_en;
                awready = awready_en;
                wready  = wready_en;
                rvalid  = rvalid_en && (r_left > 0) && (rbeat_q.size() > 0);
                rdata   = (rbeat_q.size() > 0) ? rbeat_q[0][31:0] : 32'd0;
                rresp   = (rbeat_q.size() > 0) ? rbeat_q[0][33:32] : 2'b00;
                rlast   = (r_left == 1);
                bvalid  = bvalid_en && (bresp_q.size() > 0);
                bresp   = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
            end
            #1;
            if (aresetn) begin
                if (bus_err) err_pulses++;
                if (bus_err || err_exp_next) check_val("bus_err", bus_err, err_exp_next);
                err_exp_next = 0;
                if (cpu_rvalid) begin
                    if (exp_rd_q.size() > 0) check_val("cpu_rdata", cpu_rdata, exp_rd_q.pop_front());
                    else check_val("rvalid_unexp", cpu_rvalid, 0);
                end
                ar_fire = arvalid && arready;
                if (ar_fire) begin
                    ar_total++;
                    ar_len_cap = arlen;
                    check_val("ld_after_st", b_total, store_total);
                    if (exp_ar_q.size() > 0) check_val("ar", ar_pack(araddr, arlen, arsize), exp_ar_q.pop_front());
                    else check_val("ar_unexp", arvalid, 0);
                end
                aw_fire = awvalid && awready;
                if (aw_fire) begin
                    aw_total++;
                    if (exp_aw_q.size() > 0) check_val("aw", {awaddr, 1'b0, awsize, awlen}, exp_aw_q.pop_front());
                    else check_val("aw_unexp", awvalid, 0);
                end
                w_fire = wvalid && wready;
                if (w_fire) begin
                    check_val("wlast", wlast, 1);
                    if (exp_w_q.size() > 0) check_val("w", {wdata, wstrb}, exp_w_q.pop_front());
                    else check_val("w_unexp", wvalid, 0);
                end
                r_fire = rvalid && rready;
                if (r_fire) begin
                    r_total++;
                    if (rresp[1]) err_exp_next = 1;
                end
                b_fire = bvalid && bready;
                if (b_fire) begin
                    b_total++;
                    if (bresp[1]) err_exp_next = 1;
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] d, input logic [1:0] resp);
        rbeat_q.push_back({resp, d});
        exp_rd_q.push_back(d);
    endtask

    // Tasks start and end at a falling edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] sz, input bit exp_stall, input int release_after);
        int waited = 0;
        cpu_en = 1; cpu_wen = s; cpu_addr = a; cpu_wdata = d; cpu_size = sz; cpu_line = 0;
        #3;
        check_val("st_stall_first", stall, exp_stall);
        while (stall && waited < 300) begin
            if (waited == release_after) awready_en = 1;
            @(negedge aclk); #3;
            waited++;
        end
        check_val("st_accept", stall, 0);
        if (exp_stall) check_val("st_full_pop", {b_fire, 32'(b_total)}, {1'b1, 32'd1});
        exp_aw_q.push_back({a, 1'b0, 1'b0, sz, 4'd0});
        exp_w_q.push_back({d, s});
        store_total++;
        @(negedge aclk);
        cpu_en = 0; cpu_wen = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit line,
                           input logic [31:0] ea, input logic [3:0] el, input logic [2:0] es,
                           input int exp_cycles);
        int cyc = 0;
        exp_ar_q.push_back(ar_pack(ea, el, es));
        cpu_en = 1; cpu_wen = 0; cpu_addr = a; cpu_size = sz; cpu_line = line;
        #3;
        check_val("ld_stall_now", stall, 1);
        while (stall && cyc < 300) begin
            @(negedge aclk); #3;
            cyc++;
        end
        check_val("ld_end_stall", stall, 0);
        check_val("ld_end_rvalid", cpu_rvalid, 1);
        if (exp_cycles >= 0) check_val("ld_latency", cyc, exp_cycles);
        @(negedge aclk);
        cpu_en = 0; cpu_line = 0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((b_total != store_total) && cyc < 500) begin
            @(negedge aclk);
            cyc++;
        end
        check_val("drain", b_total, store_total);
    endtask

    task automatic apply_reset();
        cpu_en = 0; cpu_wen = 0; cpu_line = 0;
        aresetn = 0;
        exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_rd_q.delete(); rbeat_q.delete();
        store_total = b_total;
        #3;
        check_val("rst_ctrl", {stall, arvalid, awvalid, wvalid, rready, bready, cpu_rvalid, bus_err}, 8'h00);
        check_val("rst_rdata", cpu_rdata, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1;
    endtask

    initial begin
        int base, cyc, aw0, ar0, e0;
        @(negedge aclk);
        apply_reset();
        @(negedge aclk);

        // word and byte loads, ready slave
        push_beat(32'hDEADBEEF, 2'b00);
        do_load(32'h1000_0004, 2'd2, 0, 32'h1000_0004, 4'd0, 3'd2, 4);
        push_beat(32'h0000_00A5, 2'b00);
        do_load(32'h1000_0013, 2'd0, 0, 32'h1000_0013, 4'd0, 3'd0, 4);

        // line load from mid-line address
        push_beat(32'h1111_1111, 2'b00);
        push_beat(32'h2222_2222, 2'b00);
        push_beat(32'h3333_3333, 2'b00);
        push_beat(32'h4444_4444, 2'b00);
        do_load(32'h2000_0008, 2'd2, 1, 32'h2000_0000, 4'd3, 3'd2, 7);

        // five stores against a stalled AW channel
        awready_en = 0;
        for (int i = 0; i < 4; i++)
            do_store(32'h5000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 2'd2, 0, -1);
        do_store(32'h5000_0010, 32'hA000_0004, 4'hF, 2'd2, 1, 5);
        drain();

        // loads wait behind buffered stores
        bvalid_en = 0;
        do_store(32'h3000_0000, 32'hCAFE_F00D, 4'hF, 2'd2, 0, -1);
        do_store(32'h3000_0001, 32'h0000_7700, 4'b0010, 2'd0, 0, -1);
        push_beat(32'h1234_5678, 2'b00);
        fork
            do_load(32'h3000_0000, 2'd2, 0, 32'h3000_0000, 4'd0, 3'd2, -1);
            begin
                repeat (8) @(negedge aclk);
                bvalid_en = 1;
            end
        join

        // error responses on B and R
        e0 = err_pulses;
        bresp_val = 2'b10;
        do_store(32'h6000_0000, 32'h0BAD_0001, 4'hF, 2'd2, 0, -1);
        drain();
        bresp_val = 2'b00;
        push_beat(32'h0BAD_0BAD, 2'b11);
        do_load(32'h6000_0000, 2'd2, 0, 32'h6000_0000, 4'd0, 3'd2, -1);
        repeat (3) @(negedge aclk);
        check_val("err_pulses", err_pulses - e0, 2);

        // reset with stores buffered
        awready_en = 0;
        do_store(32'h7000_0000, 32'h1, 4'hF, 2'd2, 0, -1);
        do_store(32'h7000_0004, 32'h2, 4'hF, 2'd2, 0, -1);
        apply_reset();
        awready_en = 1;
        aw0 = aw_total;
        ar0 = ar_total;
        repeat (20) @(negedge aclk);
        check_val("rst_no_aw", aw_total, aw0);

        // reset in the middle of a line read
        for (int i = 0; i < 4; i++) push_beat(32'hB000_0000 + 32'(i), 2'b00);
        exp_ar_q.push_back(ar_pack(32'h4000_0000, 4'd3, 3'd2));
        cpu_en = 1; cpu_wen = 0; cpu_line = 1; cpu_addr = 32'h4000_0004; cpu_size = 2'd2;
        base = r_total;
        cyc = 0;
        while (r_total < base + 2 && cyc < 100) begin
            @(negedge aclk);
            cyc++;
        end
        check_val("rd_beat2", r_total - base, 2);
        apply_reset();
        ar0 = ar_total;
        aw0 = aw_total;
        repeat (20) @(negedge aclk);
        check_val("rst_no_ar", ar_total, ar0);
        check_val("rst_no_aw2", aw_total, aw0);

        // recovery after reset
        push_beat(32'h7777_0001, 2'b00);
        do_load(32'h7000_0008, 2'd2, 0, 32'h7000_0008, 4'd0, 3'd2, 4);
        do_store(32'h7000_000C, 32'h5555_AAAA, 4'b1100, 2'd1, 0, -1);
        drain();

        repeat (3) @(negedge aclk);
        check_val("q_left", {8'(exp_ar_q.size()), 8'(exp_aw_q.size()), 8'(exp_w_q.size()), 8'(exp_rd_q.size())}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
